// File: rtl/kugelblitz_byte_capture.sv
// Passive tap on a 512-bit AXI-stream: captures one software-selected frame byte
// and exposes it, together with frame and miss statistics, over AXI-lite.
module kugelblitz_byte_capture #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,

    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,

    input  logic [AXIS_DATA_WIDTH-1:0] mon_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] mon_axis_tkeep,
    input  logic                       mon_axis_tvalid,
    input  logic                       mon_axis_tready,
    input  logic                       mon_axis_tlast
);

    if (AXIS_DATA_WIDTH != 512) begin : g_bad_width
        $error("kugelblitz_byte_capture: AXIS_DATA_WIDTH must be 512");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_SEEK     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sof_q, sof_d;
    logic [9:0]  beat_idx_q, beat_idx_d;
    logic [15:0] offset_q, offset_d;
    logic [7:0]  cap_byte_q, cap_byte_d;
    logic [15:0] cap_frame_q, cap_frame_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        beat_acc_s;
    logic [9:0]  cur_idx_s;
    logic [9:0]  tgt_beat_s;
    logic [5:0]  tgt_lane_s;
    logic [7:0]  lane_byte_s;
    logic        lane_keep_s;
    logic        seek_en_s;
    logic        eval_s;
    logic        hit_s;
    logic        miss_s;
    logic        wr_hs_s;
    logic [2:0]  wr_sel_s;
    logic        ctrl_wr_s;
    logic        off_wr_s;
    logic        rd_hs_s;
    logic [2:0]  rd_sel_s;
    logic        busy_s;
    logic        done_s;
    logic        unused_ok_s;

    assign beat_acc_s  = mon_axis_tvalid & mon_axis_tready;
    // The beat index register holds the count for the beat after an SOF only once sof drops.
    assign cur_idx_s   = sof_q ? 10'd0 : beat_idx_q;
    assign tgt_beat_s  = offset_q[15:6];
    assign tgt_lane_s  = offset_q[5:0];
    assign lane_byte_s = mon_axis_tdata[{tgt_lane_s, 3'b000} +: 8];
    assign lane_keep_s = mon_axis_tkeep[tgt_lane_s];
    assign seek_en_s   = (state_q == ST_SEEK) || ((state_q == ST_WAIT_SOF) && sof_q);
    assign eval_s      = beat_acc_s & seek_en_s;
    assign hit_s       = eval_s && (cur_idx_s == tgt_beat_s) && lane_keep_s;
    assign miss_s      = eval_s && mon_axis_tlast && !hit_s;

    assign wr_hs_s   = awready_q & s_axil_awvalid & s_axil_wvalid;
    assign wr_sel_s  = s_axil_awaddr[4:2];
    assign ctrl_wr_s = wr_hs_s && (wr_sel_s == 3'd0) && s_axil_wstrb[0];
    assign off_wr_s  = wr_hs_s && (wr_sel_s == 3'd1);
    assign rd_hs_s   = arready_q & s_axil_arvalid;
    assign rd_sel_s  = s_axil_araddr[4:2];

    assign busy_s = (state_q == ST_WAIT_SOF) || (state_q == ST_SEEK);
    assign done_s = (state_q == ST_DONE);

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = awready_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_q;

    assign unused_ok_s = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[AXIL_ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                           s_axil_araddr[AXIL_ADDR_WIDTH-1:5], s_axil_araddr[1:0],
                           s_axil_wdata[AXIL_DATA_WIDTH-1:16],
                           s_axil_wstrb[AXIL_STRB_WIDTH-1:2]};

    // Frame position tracking: sof flag and saturating beat index.
    always_comb begin
        sof_d      = sof_q;
        beat_idx_d = beat_idx_q;
        if (beat_acc_s) begin
            sof_d      = mon_axis_tlast;
            beat_idx_d = (cur_idx_s == 10'd1023) ? 10'd1023 : (cur_idx_s + 10'd1);
        end else begin
            sof_d      = sof_q;
            beat_idx_d = beat_idx_q;
        end
    end

    // Capture FSM; a CTRL write overrides whatever the stream would have done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_SOF, ST_SEEK: begin
                if (hit_s) begin
                    state_d = ST_DONE;
                end else if (miss_s) begin
                    state_d = ST_WAIT_SOF;
                end else if (eval_s) begin
                    state_d = ST_SEEK;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (ctrl_wr_s) begin
            state_d = s_axil_wdata[0] ? ST_WAIT_SOF : ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Capture registers, statistics counters and the programmable offset.
    always_comb begin
        cap_byte_d    = cap_byte_q;
        cap_frame_d   = cap_frame_q;
        frame_count_d = frame_count_q;
        miss_count_d  = miss_count_q;
        offset_d      = offset_q;
        if (hit_s && !ctrl_wr_s) begin
            cap_byte_d  = lane_byte_s;
            cap_frame_d = frame_count_q[15:0];
        end else begin
            cap_byte_d  = cap_byte_q;
            cap_frame_d = cap_frame_q;
        end
        if (beat_acc_s && mon_axis_tlast) begin
            frame_count_d = frame_count_q + 32'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
        if (miss_s) begin
            miss_count_d = miss_count_q + 32'd1;
        end else begin
            miss_count_d = miss_count_q;
        end
        if (off_wr_s) begin
            offset_d[7:0]  = s_axil_wstrb[0] ? s_axil_wdata[7:0]  : offset_q[7:0];
            offset_d[15:8] = s_axil_wstrb[1] ? s_axil_wdata[15:8] : offset_q[15:8];
        end else begin
            offset_d = offset_q;
        end
    end

    // AXI-lite handshakes: single outstanding write and read.
    always_comb begin
        awready_d = s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~awready_q;
        arready_d = s_axil_arvalid & ~rvalid_q & ~arready_q;
        if (wr_hs_s) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (rd_hs_s) begin
            rvalid_d = 1'b1;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Read data mux, sampled from current state in the ar handshake cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_hs_s) begin
            case (rd_sel_s)
                3'd0:    rdata_d = {31'd0, busy_s};
                3'd1:    rdata_d = {16'd0, offset_q};
                3'd2:    rdata_d = {30'd0, busy_s, done_s};
                3'd3:    rdata_d = {8'd0, cap_frame_q, cap_byte_q};
                3'd4:    rdata_d = frame_count_q;
                3'd5:    rdata_d = miss_count_q;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sof_q         <= 1'b1;
            beat_idx_q    <= 10'd0;
            offset_q      <= 16'd0;
            cap_byte_q    <= 8'd0;
            cap_frame_q   <= 16'd0;
            frame_count_q <= 32'd0;
            miss_count_q  <= 32'd0;
            awready_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            sof_q         <= sof_d;
            beat_idx_q    <= beat_idx_d;
            offset_q      <= offset_d;
            cap_byte_q    <= cap_byte_d;
            cap_frame_q   <= cap_frame_d;
            frame_count_q <= frame_count_d;
            miss_count_q  <= miss_count_d;
            awready_q     <= awready_d;
            bvalid_q      <= bvalid_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

endmodule
